// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver (majority-of-3 sampling, false-start
// rejection, 5..DATA_W data bits, 1/2 stop bits) feeding a first-word-fall-through FIFO.
// Optional parity support is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_ovs #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int DIV_W  = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DIV_W-1:0]       baud_div,
  input  logic [3:0]             cfg_nbits,
  input  logic                   cfg_par_en,
  input  logic                   cfg_par_odd,
  input  logic                   cfg_stop2,
  input  logic                   rx,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_ferr,
  output logic                   rd_perr,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overrun,
  input  logic                   ovr_clr,
  output logic                   rx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] IDX_S0   = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] IDX_S1   = TW'(OVS/2);
  localparam logic [TW-1:0] IDX_DEC  = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] IDX_LAST = TW'(OVS - 1);
  localparam logic [3:0]    NB_MIN   = 4'd5;
  localparam logic [3:0]    NB_MAX   = 4'(DATA_W);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY  = 3'd3,
`endif
    S_STOP    = 3'd4,
    S_BRKWAIT = 3'd5
  } state_t;

  state_t            state;
  logic              busy_q;
  logic              rx_s1, rx_s2, rx_d;
  logic [DIV_W-1:0]  cnt;
  logic [TW-1:0]     tick_idx;
  logic [3:0]        bit_cnt;
  logic              stop_idx;
  logic              smp0, smp1;
  logic [DATA_W-1:0] data_q;
  logic              ferr_q;
  logic [3:0]        nbits_sh;
  logic              stop2_sh;
  logic              perr_bit;
`ifdef UART_RX_PARITY_EN
  logic              par_en_sh, par_odd_sh, perr_q;
`endif

  logic running, tick, at_s0, at_s1, at_dec, bit_end, maj, last_stop, ferr_now;
  logic start_det, push;

  assign running   = (state == S_START) || (state == S_DATA) || (state == S_STOP)
`ifdef UART_RX_PARITY_EN
                     || (state == S_PARITY)
`endif
                     ;
  assign tick      = running && (cnt == '0);
  assign at_s0     = tick && (tick_idx == IDX_S0);
  assign at_s1     = tick && (tick_idx == IDX_S1);
  assign at_dec    = tick && (tick_idx == IDX_DEC);
  assign bit_end   = tick && (tick_idx == IDX_LAST);
  // Third sample is taken live at the decision tick.
  assign maj       = (smp0 & smp1) | (smp0 & rx_s2) | (smp1 & rx_s2);
  assign last_stop = !stop2_sh || stop_idx;
  assign ferr_now  = ferr_q | ~maj;
  assign start_det = (state == S_IDLE) && rx_d && !rx_s2;
  assign push      = (state == S_STOP) && at_dec && last_stop;
  assign rx_busy   = busy_q;
`ifdef UART_RX_PARITY_EN
  assign perr_bit  = perr_q;
`else
  assign perr_bit  = 1'b0;
`endif

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Oversample tick divider; parked at reload while no frame is in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!running || cnt == '0) begin
      cnt <= baud_div;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // Receive state machine: bit timing, majority sampling, frame assembly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      tick_idx <= '0;
      bit_cnt  <= '0;
      stop_idx <= 1'b0;
      smp0     <= 1'b1;
      smp1     <= 1'b1;
      data_q   <= '0;
      ferr_q   <= 1'b0;
      nbits_sh <= NB_MAX;
      stop2_sh <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_sh  <= 1'b0;
      par_odd_sh <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      if (tick) tick_idx <= (tick_idx == IDX_LAST) ? '0 : tick_idx + 1'b1;
      if (at_s0) smp0 <= rx_s2;
      if (at_s1) smp1 <= rx_s2;
      case (state)
        S_IDLE: begin
          if (start_det) begin
            state    <= S_START;
            busy_q   <= 1'b1;
            tick_idx <= '0;
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            data_q   <= '0;
            ferr_q   <= 1'b0;
            nbits_sh <= (cfg_nbits < NB_MIN || cfg_nbits > NB_MAX) ? NB_MAX : cfg_nbits;
            stop2_sh <= cfg_stop2;
`ifdef UART_RX_PARITY_EN
            par_en_sh  <= cfg_par_en;
            par_odd_sh <= cfg_par_odd;
            perr_q     <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (at_dec && maj) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (bit_end) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (at_dec) data_q <= data_q | (DATA_W'(maj) << bit_cnt);
          if (bit_end) begin
            if (bit_cnt == nbits_sh - 4'd1) begin
`ifdef UART_RX_PARITY_EN
              state <= par_en_sh ? S_PARITY : S_STOP;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (at_dec) perr_q <= maj ^ (^data_q) ^ par_odd_sh;
          if (bit_end) state <= S_STOP;
        end
`endif
        S_STOP: begin
          if (at_dec) begin
            ferr_q <= ferr_now;
            if (last_stop) begin
              // Framing error on all-zero data is a line break: hold until rx idles.
              if (ferr_now && data_q == '0) begin
                state <= S_BRKWAIT;
              end else begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
              end
            end
          end else if (bit_end) begin
            stop_idx <= 1'b1;
          end
        end
        S_BRKWAIT: begin
          if (rx_s2) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Receive FIFO: {perr, ferr, data} words, head visible without a read.
  logic [DATA_W+1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [DATA_W+1:0] head;
  logic              full, pop, wr;

  assign full = (count == FULL_LVL);
  assign pop  = rd_en && (count != '0);
  assign wr   = push && (!full || pop);
  assign head = mem[rd_ptr];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {perr_bit, ferr_now, data_q};
  end

  // Pointers, occupancy and sticky overrun; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop)      count <= count + 1'b1;
      else if (!wr && pop) count <= count - 1'b1;
      if (push && full && !pop) overrun <= 1'b1;
      else if (ovr_clr)         overrun <= 1'b0;
    end
  end

  assign rd_valid   = (count != '0);
  assign fifo_level = count;
  assign rd_data    = rd_valid ? head[DATA_W-1:0] : '0;
  assign rd_ferr    = rd_valid & head[DATA_W];
`ifdef UART_RX_PARITY_EN
  assign rd_perr    = rd_valid & head[DATA_W+1];
`else
  logic unused_par;
  assign unused_par = cfg_par_en ^ cfg_par_odd ^ head[DATA_W+1];
  assign rd_perr    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: frame-level reference model (expected word and push
// cycle from frame arithmetic) with a per-cycle FIFO/overrun comparison,
// plus directed literal checks and randomized frames with random reads.
module tb_uart_rx_ovs;
  localparam int D   = 3;
  localparam int OVS = 16;
  localparam int BIT = OVS * (D + 1);

  typedef struct {
    int         e;
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [15:0] bdiv = 16'(D);
  logic [3:0] cfg_nbits = 4'd8;
  logic       cfg_par_en = 1'b0, cfg_par_odd = 1'b0, cfg_stop2 = 1'b0;
  logic       rx = 1'b1, rd_en = 1'b0, ovr_clr = 1'b0;
  logic       rd_valid, rd_ferr, rd_perr, overrun, rx_busy;
  logic [7:0] rd_data;
  logic [2:0] fifo_level;

  int   errors = 0, checks = 0, edge_n = 0;
  ev_t  evq[$];
  ev_t  mq[$];
  logic m_ovr = 1'b0;
  bit   rd_mode = 1'b0;
  logic rd_req = 1'b0;
  logic vld_tr [1024];
  logic busy_tr[1024];

  always #5 clk = ~clk;

  uart_rx_ovs #(.DATA_W(8), .OVS(OVS), .DIV_W(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .baud_div(bdiv), .cfg_nbits(cfg_nbits),
    .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
    .rx(rx), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ferr(rd_ferr), .rd_perr(rd_perr), .fifo_level(fifo_level),
    .overrun(overrun), .ovr_clr(ovr_clr), .rx_busy(rx_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop1();
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    step(1);
  endtask

  // rd_en driver: random reads or the value requested by the main sequence.
  initial forever begin
    @(posedge clk);
    #2;
    rd_en = rd_mode ? ($urandom_range(0, 3) == 0) : rd_req;
  end

  // Reference FIFO: applies pops and scheduled pushes at each clock edge.
  always @(posedge clk) begin : model
    bit  pop, push, full;
    ev_t w;
    edge_n = edge_n + 1;
    if (!reset) begin
      mq.delete();
      evq.delete();
      m_ovr = 1'b0;
    end else begin
      pop  = rd_en && (mq.size() > 0);
      full = (mq.size() == 4);
      push = (evq.size() > 0) && (evq[0].e == edge_n);
      if (pop) void'(mq.pop_front());
      if (push) begin
        w = evq.pop_front();
        if (full && !pop) m_ovr = 1'b1;
        else mq.push_back(w);
      end
      if (!(push && full && !pop) && ovr_clr) m_ovr = 1'b0;
    end
  end

  // Per-cycle comparison of all FIFO-side outputs against the model.
  always @(negedge clk) begin : cmp
    if (!reset) begin
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_rd_ferr", 32'(rd_ferr), 32'd0);
      chk("rst_rd_perr", 32'(rd_perr), 32'd0);
      chk("rst_fifo_level", 32'(fifo_level), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_rx_busy", 32'(rx_busy), 32'd0);
    end else begin
      chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (mq.size() > 0) begin
        chk("rd_data", 32'(rd_data), 32'(mq[0].d));
        chk("rd_ferr", 32'(rd_ferr), 32'(mq[0].fe));
        chk("rd_perr", 32'(rd_perr), 32'(mq[0].pe));
      end else begin
        chk("rd_data_empty", 32'(rd_data), 32'd0);
      end
    end
  end

  // Drives one frame from the first start-bit cycle and schedules its expected word.
  task automatic send_frame(input logic [7:0] data, input int nb, input bit pe, input bit po,
                            input bit bp, input bit s2, input bit bs1, input bit bs2,
                            input bit rd_at_push, input bit scr, input int gap);
    int nbe, pos, last, push_off, t0;
    bit pe_eff;
    bit bits[16];
    logic [7:0] dm;
    ev_t ev;
    nbe = (nb >= 5 && nb <= 8) ? nb : 8;
`ifdef UART_RX_PARITY_EN
    pe_eff = pe;
`else
    pe_eff = 1'b0;
`endif
    dm = data & 8'((16'd1 << nbe) - 16'd1);
    bits[0] = 1'b0;
    for (int i = 0; i < nbe; i++) bits[1 + i] = dm[i];
    pos = 1 + nbe;
    if (pe_eff) begin
      bits[pos] = (^dm) ^ po ^ bp;
      pos++;
    end
    bits[pos] = !bs1;
    last = pos;
    pos++;
    if (s2) begin
      bits[pos] = !bs2;
      last = pos;
      pos++;
    end
    push_off = 3 + (last * OVS + OVS / 2 + 2) * (D + 1);
    cfg_nbits = 4'(nb); cfg_par_en = pe; cfg_par_odd = po; cfg_stop2 = s2;
    t0 = edge_n;
    ev.e = t0 + push_off; ev.d = dm; ev.fe = bs1 | (s2 & bs2); ev.pe = pe_eff & bp;
    evq.push_back(ev);
    for (int k = 0; k < pos * BIT; k++) begin
      if (k < 1024) begin
        vld_tr[k]  = rd_valid;
        busy_tr[k] = rx_busy;
      end
      rx = bits[k / BIT];
      if (rd_at_push) rd_req = (k == push_off - 1);
      if (scr && k == 2 * BIT) begin
        cfg_nbits = 4'($urandom); cfg_stop2 = 1'($urandom);
        cfg_par_en = 1'($urandom); cfg_par_odd = 1'($urandom);
      end
      step(1);
    end
    rx = 1'b1;
    if (rd_at_push) rd_req = 1'b0;
    step(gap);
  endtask

  logic [7:0] r_d;
  int         r_nb, r_gap;
  bit         r_s2, r_bs1, r_bs2, r_pe, r_po, r_bp;

  initial begin
    step(4);
    chk("reset_busy", 32'(rx_busy), 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    reset = 1'b1;
    step(10);

    // 0xA5 8N1: start detect after 3 clocks, word visible 619 clocks after the pin edge.
    send_frame(8'hA5, 8, 0, 0, 0, 0, 0, 0, 0, 0, 20);
    chk("a5_busy_pre", 32'(busy_tr[2]), 32'd0);
    chk("a5_busy_start", 32'(busy_tr[3]), 32'd1);
    chk("a5_vld_pre", 32'(vld_tr[618]), 32'd0);
    chk("a5_vld_push", 32'(vld_tr[619]), 32'd1);
    chk("a5_busy_idle", 32'(busy_tr[619]), 32'd0);
    chk("a5_data", 32'(rd_data), 32'hA5);
    chk("a5_ferr", 32'(rd_ferr), 32'd0);
    chk("a5_perr", 32'(rd_perr), 32'd0);
    pop1();

    // 20-clock glitch: false start rejected at the mid-start decision.
    for (int k = 0; k < 100; k++) begin
      busy_tr[k] = rx_busy;
      rx = (k < 20) ? 1'b0 : 1'b1;
      step(1);
    end
    chk("glitch_busy", 32'(busy_tr[5]), 32'd1);
    chk("glitch_busy_dec", 32'(busy_tr[42]), 32'd1);
    chk("glitch_idle", 32'(busy_tr[43]), 32'd0);
    chk("glitch_level", 32'(fifo_level), 32'd0);

    // Bad stop bit on 0x5A: framing error, straight back to IDLE.
    send_frame(8'h5A, 8, 0, 0, 0, 0, 1, 0, 0, 0, 10);
    chk("ferr_busy_idle", 32'(busy_tr[619]), 32'd0);
    chk("ferr_data", 32'(rd_data), 32'h5A);
    chk("ferr_flag", 32'(rd_ferr), 32'd1);
    pop1();

    // Break: 20 bit times low -> one 0x00 word with ferr, busy held until rx high.
    begin
      ev_t ev;
      ev.e = edge_n + 619; ev.d = 8'h00; ev.fe = 1'b1; ev.pe = 1'b0;
      evq.push_back(ev);
    end
    cfg_nbits = 4'd8; cfg_stop2 = 1'b0; cfg_par_en = 1'b0;
    for (int k = 0; k < 20 * BIT; k++) begin
      if (k == 1200) chk("brk_busy_held", 32'(rx_busy), 32'd1);
      rx = 1'b0;
      step(1);
    end
    rx = 1'b1;
    step(6);
    chk("brk_busy_done", 32'(rx_busy), 32'd0);
    step(2 * BIT);
    chk("brk_one_word", 32'(fifo_level), 32'd1);
    chk("brk_data", 32'(rd_data), 32'h00);
    chk("brk_ferr", 32'(rd_ferr), 32'd1);
    pop1();

    // Overrun: five bytes into a four-deep FIFO with no reads.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(4);
    chk("ovr_level", 32'(fifo_level), 32'd4);
    chk("ovr_flag", 32'(overrun), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_read", 32'(rd_data), 32'(i));
      pop1();
    end
    chk("ovr_empty", 32'(fifo_level), 32'd0);
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0; step(1);
    chk("ovr_cleared", 32'(overrun), 32'd0);
    for (int i = 1; i <= 4; i++) send_frame(8'(8'h10 + i), 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    send_frame(8'h15, 8, 0, 0, 0, 0, 0, 0, 1, 0, 4);
    chk("full_rw_level", 32'(fifo_level), 32'd4);
    chk("full_rw_ovr", 32'(overrun), 32'd0);
    chk("full_rw_head", 32'(rd_data), 32'h12);
    repeat (4) pop1();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h37, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4);
    chk("par_e_ok", 32'(rd_perr), 32'd0);
    pop1();
    send_frame(8'h37, 8, 1, 0, 1, 0, 0, 0, 0, 0, 4);
    chk("par_e_bad", 32'(rd_perr), 32'd1);
    pop1();
    send_frame(8'h41, 7, 1, 1, 0, 1, 0, 0, 0, 0, 4);
    chk("par_7o2_data", 32'(rd_data), 32'h41);
    chk("par_7o2_perr", 32'(rd_perr), 32'd0);
    pop1();
`endif

    // Reset mid-frame discards everything, including a stored word.
    send_frame(8'h11, 8, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    for (int k = 0; k < 4 * BIT; k++) begin
      rx = (k < BIT) ? 1'b0 : 1'b1;
      step(1);
    end
    reset = 1'b0;
    step(1);
    chk("rst_mid_busy", 32'(rx_busy), 32'd0);
    chk("rst_mid_level", 32'(fifo_level), 32'd0);
    step(3);
    reset = 1'b1;
    step(5);
    send_frame(8'h3C, 8, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    chk("rst_after_level", 32'(fifo_level), 32'd1);
    chk("rst_after_data", 32'(rd_data), 32'h3C);
    pop1();

    // Randomized frames with random reads, config scrambling and overrun clears.
    rd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r_d   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      r_nb  = $urandom_range(0, 15);
      r_s2  = 1'($urandom);
      r_bs1 = ($urandom_range(0, 5) == 0);
      r_bs2 = r_s2 && ($urandom_range(0, 5) == 0);
      r_pe  = 1'($urandom);
      r_po  = 1'($urandom);
      r_bp  = ($urandom_range(0, 3) == 0);
      r_gap = (r_bs1 || r_bs2) ? 8 + $urandom_range(0, 8) : $urandom_range(0, 20);
      if ($urandom_range(0, 3) == 0) begin
        ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
      end
      send_frame(r_d, r_nb, r_pe, r_po, r_bp, r_s2, r_bs1, r_bs2, 0, 1, r_gap);
    end
    rd_mode = 1'b0;
    step(2 * BIT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
